// File: rtl/fp_norm_round64_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_norm_round64_if
// Purpose  : Bundle of the data path signals between the FP64X producer, the
//            normalizer/rounder and its consumer.
// Signals  : ce          core clock enable (stalls every pipeline register)
//            rm[2:0]     rounding mode (0 RNE, 1 RTZ, 2 RUP, 3 RDN, 4 RMM,
//                        5-7 treated as RNE)
//            i_v         operand valid
//            i_sign      operand sign
//            i_exp       biased exponent (denormals already compensated to 1)
//            i_sig       significand {carry, hidden, fraction, extension}
//            o_v         result valid
//            o           packed binary64 result
//            inexact, overflow, underflow   exception flags, valid with o_v
// Modports : master drives the operand side, slave is the rounder.
// Revision : 1.0  initial release
// ============================================================================
interface fp_norm_round64_if #(
    parameter int FMSB = 51,
    parameter int EMSB = 10,
    parameter int FX   = 2*FMSB+3
);
    logic                   ce;
    logic [2:0]             rm;
    logic                   i_v;
    logic                   i_sign;
    logic [EMSB:0]          i_exp;
    logic [FX:0]            i_sig;
    logic                   o_v;
    logic [FMSB+EMSB+2:0]   o;
    logic                   inexact;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output ce, rm, i_v, i_sign, i_exp, i_sig,
        input  o_v, o, inexact, overflow, underflow
    );

    modport slave (
        input  ce, rm, i_v, i_sign, i_exp, i_sig,
        output o_v, o, inexact, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/fp_norm_round64.sv
`default_nettype none
// ============================================================================
// Module   : fp_norm_round64
// Purpose  : Five-stage normalizer/rounder turning an unnormalized FP64X
//            add/sub result into a packed IEEE-754 binary64 value.
//            Stage 1 classify + carry right shift, stage 2 leading-zero count
//            and shift clamp, stage 3 left shift + L/G/S, stage 4 rounding
//            add, stage 5 overflow/special mux into the output register.
// Ports    : clk  system clock
//            rst  synchronous active-high reset (clears valid chain, outputs)
//            bus  fp_norm_round64_if.slave (ce, rm, operand, result, flags)
// Options  : FP_NR_EXCEPT_EN  when defined, inexact/overflow/underflow are
//            computed and registered with o; otherwise they are tied to 0.
// Revision : 1.0  initial release
// ============================================================================
module fp_norm_round64 #(
    parameter int FMSB = 51,
    parameter int EMSB = 10,
    parameter int FX   = 2*FMSB+3
) (
    input  logic              clk,
    input  logic              rst,
    fp_norm_round64_if.slave  bus
);
    localparam int c_XW  = EMSB + 2;          // exponent plus one overflow bit
    localparam int c_NW  = FX;                // significand below the carry bit
    localparam int c_LZW = $clog2(FX + 1);    // holds 0..FX
    localparam int c_RW  = EMSB + FMSB + 2;   // {exp, frac}
    localparam logic [EMSB:0]   c_EXP_ONES = '1;
    localparam logic [EMSB:0]   c_EXP_MAXF = c_EXP_ONES - 1'b1;
    localparam logic [c_XW-1:0] c_X_ONE    = 1;
    localparam logic [c_XW-1:0] c_X_INF    = {1'b0, c_EXP_ONES};

    logic [4:0] r_v;

    // ---------------------------------------------------------------- stage 1
    logic                w1_special;
    logic                w1_carry;
    logic [c_XW-1:0]     w1_x;
    logic [c_NW-1:0]     w1_sig;
    logic                w1_sticky;

    always_comb begin
        w1_special = (bus.i_exp == c_EXP_ONES);
        // Specials keep their significand untouched so the payload survives.
        w1_carry   = bus.i_sig[FX] & ~w1_special;
        w1_x       = {1'b0, bus.i_exp};
        w1_sig     = bus.i_sig[FX-1:0];
        w1_sticky  = 1'b0;
        if (w1_carry) begin
            w1_x      = {1'b0, bus.i_exp} + c_X_ONE;
            w1_sig    = bus.i_sig[FX:1];
            w1_sticky = bus.i_sig[0];
        end
    end

    logic                r1_sign, r1_special, r1_sticky;
    logic [2:0]          r1_rm;
    logic [c_XW-1:0]     r1_x;
    logic [c_NW-1:0]     r1_sig;

    // ---------------------------------------------------------------- stage 2
    logic [c_LZW-1:0]    w2_lz;
    logic [c_LZW-1:0]    w2_s;
    logic [c_XW-1:0]     w2_room;

    always_comb begin
        w2_lz = c_LZW'(c_NW);
        for (int k = 0; k < c_NW; k++) begin
            if (r1_sig[k]) w2_lz = c_LZW'(c_NW - 1 - k);
        end
        // Shifting stops once the exponent reaches 1; anything still lacking
        // a hidden bit at that point is a denormal.
        w2_room = (r1_x == '0) ? '0 : r1_x - c_X_ONE;
        if (r1_special)
            w2_s = '0;
        else if ({{(c_XW-c_LZW){1'b0}}, w2_lz} <= w2_room)
            w2_s = w2_lz;
        else
            w2_s = w2_room[c_LZW-1:0];
    end

    logic                r2_sign, r2_special, r2_sticky;
    logic [2:0]          r2_rm;
    logic [c_XW-1:0]     r2_x;
    logic [c_NW-1:0]     r2_sig;
    logic [c_LZW-1:0]    r2_s;

    // ---------------------------------------------------------------- stage 3
    logic [c_NW-1:0]     w3_sh;
    logic [c_XW-1:0]     w3_x;

    always_comb begin
        w3_sh = r2_sig << r2_s;
        w3_x  = r2_x - {{(c_XW-c_LZW){1'b0}}, r2_s};
        if (!w3_sh[c_NW-1]) w3_x = '0;
    end

    logic                r3_sign, r3_special;
    logic [2:0]          r3_rm;
    logic [c_XW-1:0]     r3_x;
    logic [FMSB:0]       r3_frac;
    logic                r3_l, r3_g, r3_s;

    // ---------------------------------------------------------------- stage 4
    logic                w4_inc;
    logic [c_RW-1:0]     w4_sum;

    always_comb begin
        case (r3_rm)
            3'd1:    w4_inc = 1'b0;
            3'd2:    w4_inc = ~r3_sign & (r3_g | r3_s);
            3'd3:    w4_inc =  r3_sign & (r3_g | r3_s);
            3'd4:    w4_inc = r3_g;
            default: w4_inc = r3_g & (r3_l | r3_s);
        endcase
        // A fraction carry ripples into the exponent: this covers mantissa
        // wrap and denormal-to-normal promotion without extra logic.
        w4_sum = {r3_x[EMSB:0], r3_frac} + {{(c_RW-1){1'b0}}, w4_inc};
        if (r3_special) w4_sum = {c_EXP_ONES, r3_frac};
    end

    logic                r4_sign, r4_special, r4_pre_ovf;
    logic [2:0]          r4_rm;
    logic [c_RW-1:0]     r4_sum;
`ifdef FP_NR_EXCEPT_EN
    logic                r4_gs;
`endif

    // ---------------------------------------------------------------- stage 5
    logic [EMSB:0]       w5_exp;
    logic                w5_ovf;
    logic                w5_maxfin;
    logic [c_RW:0]       w5_res;

    always_comb begin
        w5_exp    = r4_sum[c_RW-1 -: EMSB+1];
        w5_ovf    = ~r4_special & (r4_pre_ovf | (w5_exp == c_EXP_ONES));
        // Modes rounding toward zero for this sign saturate at max finite.
        w5_maxfin = (r4_rm == 3'd1) | ((r4_rm == 3'd2) & r4_sign) |
                    ((r4_rm == 3'd3) & ~r4_sign);
        w5_res    = {r4_sign, r4_sum};
        if (w5_ovf)
            w5_res = w5_maxfin ? {r4_sign, c_EXP_MAXF, {(FMSB+1){1'b1}}}
                               : {r4_sign, c_EXP_ONES, {(FMSB+1){1'b0}}};
    end

    // ------------------------------------------------- data pipeline registers
    always_ff @(posedge clk) begin
        if (bus.ce) begin
            r1_sign    <= bus.i_sign;
            r1_special <= w1_special;
            r1_sticky  <= w1_sticky;
            r1_rm      <= bus.rm;
            r1_x       <= w1_x;
            r1_sig     <= w1_sig;

            r2_sign    <= r1_sign;
            r2_special <= r1_special;
            r2_sticky  <= r1_sticky;
            r2_rm      <= r1_rm;
            r2_x       <= r1_x;
            r2_sig     <= r1_sig;
            r2_s       <= w2_s;

            r3_sign    <= r2_sign;
            r3_special <= r2_special;
            r3_rm      <= r2_rm;
            r3_x       <= w3_x;
            r3_frac    <= w3_sh[c_NW-2 -: FMSB+1];
            r3_l       <= w3_sh[c_NW-2-FMSB];
            r3_g       <= w3_sh[FMSB];
            r3_s       <= (|w3_sh[FMSB-1:0]) | r2_sticky;

            r4_sign    <= r3_sign;
            r4_special <= r3_special;
            r4_rm      <= r3_rm;
            r4_sum     <= w4_sum;
            r4_pre_ovf <= ~r3_special & (r3_x >= c_X_INF);
`ifdef FP_NR_EXCEPT_EN
            r4_gs      <= r3_g | r3_s;
`endif
        end
    end

    // ------------------------------------------------- valid chain and output
    logic [c_RW:0] r_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
            r_o <= '0;
        end else if (bus.ce) begin
            r_v <= {r_v[3:0], bus.i_v};
            // Idle slots present zero so flushed operands never leak out.
            r_o <= r_v[3] ? w5_res : '0;
        end
    end

    assign bus.o_v = r_v[4];
    assign bus.o   = r_o;

`ifdef FP_NR_EXCEPT_EN
    logic r_inexact, r_overflow, r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inexact   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.ce) begin
            r_inexact   <= r_v[3] & ~r4_special & (w5_ovf | r4_gs);
            r_overflow  <= r_v[3] & w5_ovf;
            r_underflow <= r_v[3] & ~r4_special & ~w5_ovf & r4_gs &
                           (w5_exp == '0);
        end
    end

    assign bus.inexact   = r_inexact;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`else
    assign bus.inexact   = 1'b0;
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fp_norm_round64.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_norm_round64
// Purpose  : Scoreboard bench for fp_norm_round64 with directed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_norm_round64;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_norm_round64_if bus ();
    fp_norm_round64 dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef FP_NR_EXCEPT_EN
    localparam bit c_EXC = 1'b1;
`else
    localparam bit c_EXC = 1'b0;
`endif

    typedef struct {
        logic [63:0] o;
        logic [2:0]  fl;
        int          lat;
        int          t0;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    function automatic logic [105:0] b(int n);
        logic [105:0] one;
        one = 106'd1;
        return one << n;
    endfunction

    task automatic issue(string nm, bit sg, logic [10:0] ex, logic [105:0] sig,
                         logic [2:0] m, logic [63:0] eo, bit fi, bit fo, bit fu,
                         int lat = 5);
        exp_t e;
        @(negedge clk);
        bus.i_v    = 1'b1;
        bus.i_sign = sg;
        bus.i_exp  = ex;
        bus.i_sig  = sig;
        bus.rm     = m;
        e.o    = eo;
        e.fl   = c_EXC ? {fi, fo, fu} : 3'b000;
        e.lat  = lat;
        e.t0   = cyc;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.i_v = 1'b0;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results pending after %0d cycles, expected 0",
                     sb.size(), budget);
            sb.delete();
        end
    endtask

    // Monitor: pops one expectation per enabled edge that presents o_v, and
    // checks the outputs stay frozen across disabled edges.
    initial begin : monitor
        exp_t        e;
        logic        ce_at, rst_at, prev_v;
        logic [63:0] prev_o;
        prev_v = 1'b0;
        prev_o = '0;
        forever begin
            @(posedge clk);
            ce_at  = bus.ce;
            rst_at = rst;
            #1;
            if (!rst_at && ce_at === 1'b0) begin
                chk("hold o_v", {63'd0, bus.o_v}, {63'd0, prev_v});
                chk("hold o", bus.o, prev_o);
            end else if (bus.o_v === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected o_v: got o=%h, expected no output", bus.o);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, " o"}, bus.o, e.o);
                    chk({e.name, " flags"},
                        {61'd0, bus.inexact, bus.overflow, bus.underflow},
                        {61'd0, e.fl});
                    chk({e.name, " latency"}, 64'(cyc - e.t0), 64'(e.lat));
                end
            end
            prev_v = bus.o_v;
            prev_o = bus.o;
        end
    end

    logic [105:0] v_ones, v_dn;

    initial begin
        rst        = 1'b1;
        bus.ce     = 1'b1;
        bus.i_v    = 1'b0;
        bus.i_sign = 1'b0;
        bus.i_exp  = '0;
        bus.i_sig  = '0;
        bus.rm     = '0;
        v_ones     = {1'b0, {54{1'b1}}, {51{1'b0}}};
        v_dn       = {2'b00, {53{1'b1}}, {51{1'b0}}};
        repeat (3) @(negedge clk);
        chk("reset o_v", {63'd0, bus.o_v}, 64'd0);
        chk("reset o", bus.o, 64'd0);
        chk("reset flags", {61'd0, bus.inexact, bus.overflow, bus.underflow}, 64'd0);
        rst = 1'b0;

        // Back-to-back directed vectors
        issue("carry",      0, 11'h3FF, b(105),               3'd0, 64'h4000000000000000, 0, 0, 0);
        issue("tie rne",    0, 11'h3FF, b(104) | b(51),       3'd0, 64'h3FF0000000000000, 1, 0, 0);
        issue("tie rmm",    0, 11'h3FF, b(104) | b(51),       3'd4, 64'h3FF0000000000001, 1, 0, 0);
        issue("cancel",     0, 11'h3FF, b(52),                3'd0, 64'h3CB0000000000000, 0, 0, 0);
        issue("ovf rne",    0, 11'h7FE, b(105),               3'd0, 64'h7FF0000000000000, 1, 1, 0);
        issue("ovf rtz",    0, 11'h7FE, b(105),               3'd1, 64'h7FEFFFFFFFFFFFFF, 1, 1, 0);
        issue("denorm",     0, 11'h001, b(103),               3'd0, 64'h0008000000000000, 0, 0, 0);
        issue("denorm rup", 0, 11'h001, b(103) | b(0),        3'd2, 64'h0008000000000001, 1, 0, 1);
        issue("nan",        0, 11'h7FF, b(103),               3'd0, 64'h7FF8000000000000, 0, 0, 0);
        issue("zero",       1, 11'h400, '0,                   3'd0, 64'h8000000000000000, 0, 0, 0);
        issue("ovf rup neg",1, 11'h7FE, b(105),               3'd2, 64'hFFEFFFFFFFFFFFFF, 1, 1, 0);
        issue("ovf rdn neg",1, 11'h7FE, b(105),               3'd3, 64'hFFF0000000000000, 1, 1, 0);
        issue("rm5 tie odd",0, 11'h3FF, b(104) | b(52) | b(51), 3'd5, 64'h3FF0000000000002, 1, 0, 0);
        issue("rdn neg",    1, 11'h3FF, b(104) | b(0),        3'd3, 64'hBFF0000000000001, 1, 0, 0);
        issue("rup neg",    1, 11'h3FF, b(104) | b(0),        3'd2, 64'hBFF0000000000000, 1, 0, 0);
        issue("wrap",       0, 11'h3FF, v_ones,               3'd0, 64'h4000000000000000, 1, 0, 0);
        issue("post ovf",   0, 11'h7FE, v_ones,               3'd0, 64'h7FF0000000000000, 1, 1, 0);
        issue("dn to norm", 0, 11'h001, v_dn,                 3'd0, 64'h0010000000000000, 1, 0, 0);
        issue("carry stk",  0, 11'h3FF, b(105) | b(0),        3'd2, 64'h4000000000000001, 1, 0, 0);
        issue("clamp",      0, 11'h003, b(100),               3'd0, 64'h0004000000000000, 0, 0, 0);
        idle();
        drain(40);

        // Clock-enable stall: first result leaves, then a 3-cycle stall
        // holds it on the output while the second one waits.
        issue("pre stall",  0, 11'h3FF, b(105),               3'd0, 64'h4000000000000000, 0, 0, 0);
        issue("stalled",    0, 11'h3FF, b(52),                3'd0, 64'h3CB0000000000000, 0, 0, 0, 8);
        idle();
        idle();
        idle();
        @(negedge clk);
        bus.ce = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.ce = 1'b1;
        drain(40);

        // Reset while an operand sits in stage 3; it must vanish. ce is held
        // low during reset to show reset wins over the enable.
        @(negedge clk);
        bus.i_v    = 1'b1;
        bus.i_sign = 1'b0;
        bus.i_exp  = 11'h3FF;
        bus.i_sig  = b(105);
        bus.rm     = 3'd0;
        idle();
        idle();
        @(negedge clk);
        rst    = 1'b1;
        bus.ce = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        bus.ce = 1'b1;
        chk("flush o_v", {63'd0, bus.o_v}, 64'd0);
        chk("flush o", bus.o, 64'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("flush o_v", {63'd0, bus.o_v}, 64'd0);
            chk("flush o", bus.o, 64'd0);
        end

        // Pipeline still works after the flush
        issue("post rst",   0, 11'h3FF, b(104) | b(51),       3'd4, 64'h3FF0000000000001, 1, 0, 0);
        idle();
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
